// File: rtl/pe_seq_if.sv
// pe_seq_if: bundles the command handshake, the beat handshake and the registered PE drive.
// Ports: cmd_* (command + valid/ready), in_* (beat data + valid/ready), pe_* and done (to the PE).
// master = command/beat source and PE sink; slave = the pe_seq sequencer.
interface pe_seq_if #(
    parameter int PRECISION = 16,
    parameter int REG_SIZE  = 4,
    parameter int LEN_W     = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_store;
    logic                 cmd_reuse;
    logic [REG_SIZE-1:0]  cmd_addr;

    logic                 in_valid;
    logic                 in_ready;
    logic [PRECISION-1:0] in_act;
    logic [PRECISION-1:0] in_wgt;

    logic [PRECISION-1:0] pe_act;
    logic [PRECISION-1:0] pe_wgt;
    logic                 pe_store;
    logic                 pe_reuse;
    logic                 pe_finish;
    logic [REG_SIZE-1:0]  pe_addr;
    logic                 done;

    modport master (
        output cmd_valid, cmd_len, cmd_store, cmd_reuse, cmd_addr,
        output in_valid, in_act, in_wgt,
        input  cmd_ready, in_ready,
        input  pe_act, pe_wgt, pe_store, pe_reuse, pe_finish, pe_addr, done
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_store, cmd_reuse, cmd_addr,
        input  in_valid, in_act, in_wgt,
        output cmd_ready, in_ready,
        output pe_act, pe_wgt, pe_store, pe_reuse, pe_finish, pe_addr, done
    );
endinterface

// File: rtl/pe_seq.sv
// pe_seq: sequences one dot-product command (len beats of act/wgt) into a PE with registered drive.
// Latency: beat shows on pe_act/pe_wgt one cycle after acceptance; pe_finish/done two cycles after the last beat.
// Backpressure: cmd_ready only in IDLE, in_ready only in STREAM; clk/rst are sync active-high.
// Optional: define PE_SEQ_ADDR_CHECK_EN to add the err output, which flags store/reuse to address 0
// and strips the store/reuse mode from that command.
module pe_seq #(
    parameter int PRECISION = 16,
    parameter int REG_SIZE  = 4,
    parameter int LEN_W     = 8
) (
    input  logic    clk,
    input  logic    rst,
    pe_seq_if.slave bus
`ifdef PE_SEQ_ADDR_CHECK_EN
    ,
    output logic    err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    count;
    logic                lat_store;
    logic                lat_reuse;
    logic [REG_SIZE-1:0] lat_addr;
    logic                first;
    logic                bad_addr;

    // Handshake readies are pure decodes of the state register.
    assign bus.cmd_ready = (state == IDLE);
    assign bus.in_ready  = (state == STREAM);
    assign bus.pe_addr   = lat_addr;

`ifdef PE_SEQ_ADDR_CHECK_EN
    // Address 0 is reserved in the PE regfile; a store/reuse there is refused.
    assign bad_addr = (bus.cmd_addr == '0) && (bus.cmd_store || bus.cmd_reuse);
`else
    assign bad_addr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            lat_store     <= 1'b0;
            lat_reuse     <= 1'b0;
            lat_addr      <= '0;
            first         <= 1'b0;
            bus.pe_act    <= '0;
            bus.pe_wgt    <= '0;
            bus.pe_store  <= 1'b0;
            bus.pe_reuse  <= 1'b0;
            bus.pe_finish <= 1'b0;
            bus.done      <= 1'b0;
`ifdef PE_SEQ_ADDR_CHECK_EN
            err           <= 1'b0;
`endif
        end else begin
            // Default drive is all-zero so the PE's unconditional MAC adds nothing.
            bus.pe_act    <= '0;
            bus.pe_wgt    <= '0;
            bus.pe_store  <= 1'b0;
            bus.pe_reuse  <= 1'b0;
            bus.pe_finish <= 1'b0;
            bus.done      <= 1'b0;
`ifdef PE_SEQ_ADDR_CHECK_EN
            err           <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        count     <= bus.cmd_len;
                        lat_addr  <= bus.cmd_addr;
                        lat_store <= bus.cmd_store && !bad_addr;
                        lat_reuse <= bus.cmd_reuse && !bad_addr;
                        first     <= 1'b1;
`ifdef PE_SEQ_ADDR_CHECK_EN
                        err       <= bad_addr;
`endif
                        if (bus.cmd_len == '0) begin
                            state         <= FINISH;
                            bus.pe_finish <= 1'b1;
                            bus.done      <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (bus.in_valid) begin
                        bus.pe_act   <= bus.in_act;
                        bus.pe_wgt   <= bus.in_wgt;
                        // With store+reuse the first beat writes the weight and uses it
                        // directly; only later beats read it back.
                        bus.pe_store <= lat_store && first;
                        bus.pe_reuse <= lat_reuse && !(lat_store && first);
                        first        <= 1'b0;
                        count        <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state         <= FINISH;
                    bus.pe_finish <= 1'b1;
                    bus.done      <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq.sv
module tb_pe_seq;
    localparam int P = 16;
    localparam int R = 4;
    localparam int L = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_seq_if #(.PRECISION(P), .REG_SIZE(R), .LEN_W(L)) bus ();
`ifdef PE_SEQ_ADDR_CHECK_EN
    logic err;
`endif

    pe_seq #(.PRECISION(P), .REG_SIZE(R), .LEN_W(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PE_SEQ_ADDR_CHECK_EN
        ,
        .err (err)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream PE: regfile of weights plus an unconditional MAC, result latched on pe_finish.
    logic [P-1:0] pe_rf [16] = '{default: '0};
    logic [63:0]  pe_acc = '0;
    logic [63:0]  pe_out = '0;
    logic [P-1:0] w_eff;
    assign w_eff = (bus.pe_reuse && !bus.pe_store) ? pe_rf[bus.pe_addr] : bus.pe_wgt;
    always @(posedge clk) begin
        if (rst) begin
            pe_acc <= '0;
        end else begin
            if (bus.pe_store) pe_rf[bus.pe_addr] <= bus.pe_wgt;
            if (bus.pe_finish) begin
                pe_out <= pe_acc + 64'(bus.pe_act) * 64'(w_eff);
                pe_acc <= '0;
            end else begin
                pe_acc <= pe_acc + 64'(bus.pe_act) * 64'(w_eff);
            end
        end
    end

    // Expected regfile contents, derived from the command rules only.
    logic [P-1:0] rf_exp [16] = '{default: '0};
    logic [P-1:0] beat_act [$];
    logic [P-1:0] beat_wgt [$];

    task automatic run_cmd(input int len, input bit st, input bit re, input logic [R-1:0] addr,
                           input int gap, output int t_acc);
        bit          force_off, st_e, re_e, rdy, vld, got;
        bit          exp_s, exp_r;
        int          k, n, gap_left;
        logic [P-1:0] w;
        logic [63:0] exp_sum;
        force_off = 1'b0;
`ifdef PE_SEQ_ADDR_CHECK_EN
        force_off = (addr == '0) && (st || re);
`endif
        st_e = st && !force_off;
        re_e = re && !force_off;
        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            if (st_e && i == 0) begin
                w = beat_wgt[i];
                rf_exp[addr] = beat_wgt[i];
            end else if (re_e) begin
                w = rf_exp[addr];
            end else begin
                w = beat_wgt[i];
            end
            exp_sum = exp_sum + 64'(beat_act[i]) * 64'(w);
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_len   = L'(len);
        bus.cmd_store = st;
        bus.cmd_reuse = re;
        bus.cmd_addr  = addr;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            rdy = bus.cmd_ready;
            @(posedge clk); #1;
            got = rdy;
            n++;
        end
        t_acc = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1 within 20 cycles", bus.cmd_ready);
        end
        // Keep offering a different command while busy; it must not be taken.
        bus.cmd_addr = addr ^ R'(1);
        bus.cmd_len  = L'($urandom_range(1, 5));
        if (len == 0) bus.cmd_valid = 1'b0;
`ifdef PE_SEQ_ADDR_CHECK_EN
        checks++;
        if (err !== force_off) begin
            errors++;
            $display("FAIL err_pulse: got %0b required %0b", err, force_off);
        end
`endif

        if (len == 0) begin
            checks++;
            if ({bus.pe_finish, bus.done, bus.pe_store, bus.pe_reuse, bus.pe_act} !== {1'b1, 1'b1, 1'b0, 1'b0, P'(0)}) begin
                errors++;
                $display("FAIL zero_len_finish: fin/done/st/ru/act=%0b%0b%0b%0b/%0h required 1100/0",
                         bus.pe_finish, bus.done, bus.pe_store, bus.pe_reuse, bus.pe_act);
            end
        end else begin
            k = 0;
            n = 0;
            gap_left = 0;
            while (k < len && n < 200) begin
                vld = (gap_left == 0);
                bus.in_valid = vld;
                bus.in_act = vld ? beat_act[k] : P'($urandom);
                bus.in_wgt = vld ? beat_wgt[k] : P'($urandom);
                rdy = bus.in_ready;
                @(posedge clk); #1;
                n++;
                if (vld && rdy) begin
                    exp_s = st_e && (k == 0);
                    exp_r = re_e && !(st_e && (k == 0));
                    checks++;
                    if ({bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr, bus.cmd_ready}
                        !== {beat_act[k], beat_wgt[k], exp_s, exp_r, 1'b0, addr, 1'b0}) begin
                        errors++;
                        $display("FAIL beat%0d: act=%0h wgt=%0h st=%0b ru=%0b fin=%0b addr=%0h crdy=%0b required act=%0h wgt=%0h st=%0b ru=%0b fin=0 addr=%0h crdy=0",
                                 k, bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr,
                                 bus.cmd_ready, beat_act[k], beat_wgt[k], exp_s, exp_r, addr);
                    end
                    k++;
                    gap_left = gap;
                end else begin
                    if (gap_left > 0) gap_left--;
                    checks++;
                    if ({bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.cmd_ready} !== '0) begin
                        errors++;
                        $display("FAIL bubble: act=%0h wgt=%0h st=%0b ru=%0b fin=%0b crdy=%0b required all 0",
                                 bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.cmd_ready);
                    end
                end
            end
            checks++;
            if (k < len) begin
                errors++;
                $display("FAIL beat_timeout: accepted %0d beats required %0d", k, len);
            end
            // In DRAIN now: junk beats must be ignored, stale command dropped.
            bus.cmd_valid = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_act    = P'($urandom);
            bus.in_wgt    = P'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({bus.pe_finish, bus.done, bus.pe_act, bus.pe_store, bus.pe_reuse} !== {1'b1, 1'b1, P'(0), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL finish: fin=%0b done=%0b act=%0h st=%0b ru=%0b required 1 1 0 0 0",
                         bus.pe_finish, bus.done, bus.pe_act, bus.pe_store, bus.pe_reuse);
            end
        end

        @(posedge clk); #1;
        checks++;
        if ({bus.pe_finish, bus.done, bus.cmd_ready, bus.in_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL back_to_idle: fin/done/crdy/irdy=%0b%0b%0b%0b required 0010",
                     bus.pe_finish, bus.done, bus.cmd_ready, bus.in_ready);
        end
        checks++;
        if (pe_out !== exp_sum) begin
            errors++;
            $display("FAIL pe_out: got %0d required %0d", pe_out, exp_sum);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd3;
        bus.cmd_store = 1'b1;
        bus.cmd_reuse = 1'b1;
        bus.cmd_addr  = 4'd7;
        bus.in_valid  = 1'b1;
        bus.in_act    = 16'h1234;
        bus.in_wgt    = 16'h5678;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr, bus.done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: act=%0h wgt=%0h st=%0b ru=%0b fin=%0b addr=%0h done=%0b required all 0",
                         bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr, bus.done);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        rst = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_ready: crdy=%0b irdy=%0b required 1 0", bus.cmd_ready, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int t;
        beat_act = '{16'd2, 16'd4, 16'd1};
        beat_wgt = '{16'd3, 16'd5, 16'd7};
        run_cmd(3, 1'b0, 1'b0, 4'd1, 0, t);
        checks++;
        if (pe_out !== 64'd33) begin
            errors++;
            $display("FAIL basic_33: got %0d required 33", pe_out);
        end
    endtask

    task automatic test_store_reuse();
        int t;
        beat_act = '{16'd3, 16'd5};
        beat_wgt = '{16'd4, 16'd9};
        run_cmd(2, 1'b1, 1'b1, 4'd2, 0, t);
        checks++;
        if (pe_out !== 64'd32) begin
            errors++;
            $display("FAIL store_reuse_32: got %0d required 32", pe_out);
        end
    endtask

    task automatic test_gaps();
        int t;
        logic [63:0] no_gap;
        beat_act = '{16'd6, 16'd11};
        beat_wgt = '{16'd2, 16'd3};
        run_cmd(2, 1'b0, 1'b0, 4'd3, 0, t);
        no_gap = pe_out;
        run_cmd(2, 1'b0, 1'b0, 4'd3, 3, t);
        checks++;
        if (pe_out !== no_gap || pe_out !== 64'd45) begin
            errors++;
            $display("FAIL gaps_same_result: got %0d required %0d (45)", pe_out, no_gap);
        end
    endtask

    task automatic test_zero_len();
        int t;
        beat_act = {};
        beat_wgt = {};
        run_cmd(0, 1'b1, 1'b0, 4'd4, 0, t);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        beat_act = '{16'd1, 16'd2, 16'd3, 16'd4};
        beat_wgt = '{16'd5, 16'd6, 16'd7, 16'd8};
        run_cmd(4, 1'b0, 1'b0, 4'd5, 0, t1);
        run_cmd(4, 1'b1, 1'b0, 4'd5, 0, t2);
        checks++;
        if (t2 - t1 !== 7) begin
            errors++;
            $display("FAIL cmd_spacing: got %0d cycles required 7", t2 - t1);
        end
    endtask

    task automatic test_reset_mid();
        bit saw;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd4;
        bus.cmd_store = 1'b0;
        bus.cmd_reuse = 1'b0;
        bus.cmd_addr  = 4'd9;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_act    = 16'd6;
        bus.in_wgt    = 16'd7;
        @(posedge clk); #1;
        checks++;
        if ({bus.pe_act, bus.pe_wgt} !== {16'd6, 16'd7}) begin
            errors++;
            $display("FAIL mid_beat1: act=%0h wgt=%0h required 6 7", bus.pe_act, bus.pe_wgt);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr, bus.done} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: act=%0h wgt=%0h st=%0b ru=%0b fin=%0b addr=%0h done=%0b required all 0",
                     bus.pe_act, bus.pe_wgt, bus.pe_store, bus.pe_reuse, bus.pe_finish, bus.pe_addr, bus.done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.cmd_ready, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_ready: crdy=%0b irdy=%0b required 1 0", bus.cmd_ready, bus.in_ready);
        end
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.pe_finish || bus.done) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_finish: saw finish=%0b required 0", saw);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        int t, len;
        for (int c = 0; c < 25; c++) begin
            len = $urandom_range(0, 6);
            beat_act = {};
            beat_wgt = {};
            for (int i = 0; i < len; i++) begin
                beat_act.push_back(P'($urandom));
                beat_wgt.push_back(P'($urandom));
            end
            run_cmd(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), R'($urandom_range(0, 15)),
                    $urandom_range(0, 2), t);
        end
    endtask

`ifdef PE_SEQ_ADDR_CHECK_EN
    task automatic test_addr_err();
        int t;
        beat_act = '{16'd3, 16'd5};
        beat_wgt = '{16'd4, 16'd9};
        run_cmd(2, 1'b0, 1'b1, 4'd0, 0, t);
        checks++;
        if (pe_out !== 64'd57) begin
            errors++;
            $display("FAIL addr_err_result: got %0d required 57", pe_out);
        end
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_store = 1'b0;
        bus.cmd_reuse = 1'b0;
        bus.cmd_addr  = '0;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        test_reset();
        test_basic();
        test_store_reuse();
        test_gaps();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
`ifdef PE_SEQ_ADDR_CHECK_EN
        test_addr_err();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
